hazard_detection_unit: RTL and testbench

//  Producer of the is_hazard stall request consumed by ControlUnit in the 5-stage RISC-V pipeline.

---
 rtl/hazard_detection_unit.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_detection_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//   Stall generator for a 5-stage RISC-V pipeline. A shadow copy of the destination-register
//   state of the EX and MEM stages is kept here. Each cycle the source registers of the ID-stage
//   instruction are compared against that shadow state. On a dependency the unit raises
//   is_hazard_o and holds the PC and the IF/ID register for that cycle. Stall cycles are counted
//   in a saturating performance counter.
//
//   Build option: define FORWARD_EN when the datapath has EX/MEM forwarding. Only load-use
//   dependencies, and ECALL reading x17 in ID, then cause a stall. Without FORWARD_EN, any
//   dependency on an instruction in EX or MEM stalls.
//
// Parameters
//   REG_ADDR_W    register index width
//   STALL_CNT_W   width of the stall-cycle counter
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   id_inst_i      instruction currently held in IF/ID
//   id_valid_i     IF/ID holds a real instruction (0 = bubble)
//   flush_i        branch/jump redirect; the ID instruction is killed this cycle
//   is_hazard_o    stall request to the control unit
//   pc_write_o     0 = hold PC
//   ifid_write_o   0 = hold IF/ID register
//   stall_count_o  saturating count of cycles with is_hazard_o = 1

module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [31:0]            id_inst_i,
  input  logic                   id_valid_i,
  input  logic                   flush_i,
  output logic                   is_hazard_o,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  // RV32I major opcodes.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpArith  = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // ECALL takes its service number from a7 (x17), so x17 is a source for the halt check.
  localparam logic [REG_ADDR_W-1:0] EcallArgReg = REG_ADDR_W'(17);

  // ---------------------------------------------------------------------------------------------
  // ID-stage decode
  // ---------------------------------------------------------------------------------------------
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1_field;
  logic [REG_ADDR_W-1:0] rs2_field;
  logic [REG_ADDR_W-1:0] rd_field;
  logic [REG_ADDR_W-1:0] src1;
  logic                  is_load;
  logic                  is_store;
  logic                  is_branch;
  logic                  is_jal;
  logic                  is_arith;
  logic                  is_ecall;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  writes_rd;

  always_comb begin
    opcode    = id_inst_i[6:0];
    rs1_field = REG_ADDR_W'(id_inst_i[19:15]);
    rs2_field = REG_ADDR_W'(id_inst_i[24:20]);
    rd_field  = REG_ADDR_W'(id_inst_i[11:7]);

    is_load   = (opcode == OpLoad);
    is_store  = (opcode == OpStore);
    is_branch = (opcode == OpBranch);
    is_jal    = (opcode == OpJal);
    is_arith  = (opcode == OpArith);
    is_ecall  = (opcode == OpSystem);

    src1      = is_ecall ? EcallArgReg : rs1_field;
    uses_rs1  = !is_jal;
    uses_rs2  = is_arith || is_store || is_branch;
    writes_rd = !(is_store || is_branch || is_ecall) && (rd_field != '0);
  end

  // Funct and immediate fields do not affect register dependencies.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst_i[31:25], id_inst_i[14:12]};

  // ---------------------------------------------------------------------------------------------
  // Shadow EX/MEM destination state
  // ---------------------------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_wr_q, ex_wr_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;

  // ---------------------------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------------------------
  logic src1_live;
  logic src2_live;
  logic match_ex;
  logic match_mem;
  logic hazard_cond;
  logic is_hazard;

  always_comb begin
    // x0 is hard-wired, so a read of x0 never depends on anything in flight.
    src1_live = uses_rs1 && (src1 != '0);
    src2_live = uses_rs2 && (rs2_field != '0);

    match_ex  = ex_wr_q && ((src1_live && (src1 == ex_rd_q)) ||
                            (src2_live && (rs2_field == ex_rd_q)));
    match_mem = mem_wr_q && ((src1_live && (src1 == mem_rd_q)) ||
                             (src2_live && (rs2_field == mem_rd_q)));
  end

`ifdef FORWARD_EN
  // Forwarding covers everything except a load still in EX and the ECALL check, which is
  // evaluated in ID where no forwarding path reaches.
  always_comb begin
    hazard_cond = (ex_mem_read_q && match_ex) || (is_ecall && (match_ex || match_mem));
  end
`else
  always_comb begin
    hazard_cond = match_ex || match_mem;
  end

  // The load flag is only consulted when forwarding is present.
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read_q;
`endif

  // A flush kills the ID instruction, so it can never be the cause of a stall.
  assign is_hazard    = id_valid_i && !flush_i && hazard_cond;
  assign is_hazard_o  = is_hazard;
  assign pc_write_o   = !is_hazard;
  assign ifid_write_o = !is_hazard;

  // ---------------------------------------------------------------------------------------------
  // Shadow pipeline advance
  // ---------------------------------------------------------------------------------------------
  logic insert_bubble;

  always_comb begin
    // A stall does not freeze EX/MEM: the held instruction stays in ID while a bubble moves on.
    insert_bubble = is_hazard || flush_i || !id_valid_i;

    ex_rd_d       = insert_bubble ? '0 : rd_field;
    ex_wr_d       = !insert_bubble && writes_rd;
    ex_mem_read_d = !insert_bubble && is_load;

    mem_rd_d      = ex_rd_q;
    mem_wr_d      = ex_wr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_rd_q       <= '0;
      ex_wr_q       <= 1'b0;
      ex_mem_read_q <= 1'b0;
      mem_rd_q      <= '0;
      mem_wr_q      <= 1'b0;
    end else begin
      ex_rd_q       <= ex_rd_d;
      ex_wr_q       <= ex_wr_d;
      ex_mem_read_q <= ex_mem_read_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stall-cycle performance counter (saturating)
  // ---------------------------------------------------------------------------------------------
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (is_hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboarded bench for hazard_detection_unit. A reference model tracks the destination
// registers of the two most recent instructions that entered EX. For every cycle it pushes the
// expected outputs into a queue, and a monitor pops and compares them at the falling edge.

module tb_hazard_detection_unit;

  localparam int unsigned CntW   = 8;
  localparam int          CntMax = 255;

`ifdef FORWARD_EN
  localparam int LuStalls = 1;
`else
  localparam int LuStalls = 2;
`endif

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpArith  = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     id_inst;
  logic            id_valid;
  logic            flush;
  logic            is_hazard;
  logic            pc_write;
  logic            ifid_write;
  logic [CntW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_detection_unit #(
    .REG_ADDR_W (5),
    .STALL_CNT_W(CntW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .id_inst_i    (id_inst),
    .id_valid_i   (id_valid),
    .flush_i      (flush),
    .is_hazard_o  (is_hazard),
    .pc_write_o   (pc_write),
    .ifid_write_o (ifid_write),
    .stall_count_o(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------------------------
  typedef struct {
    int rd;    // register written by the instruction (0 = none)
    bit load;
  } prod_t;

  typedef struct {
    logic            haz;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  prod_t hist[$];    // [0] = instruction now in EX, [1] = instruction now in MEM
  prod_t p_enter;    // what enters EX at the next edge
  bit    p_haz;
  bit    m_haz;
  int    m_cnt;

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2);
    logic [4:0] a, b, d;
    a = rs1[4:0];
    b = rs2[4:0];
    d = rd[4:0];
    return {7'b0, b, a, 3'b0, d, op};
  endfunction

  function automatic bit model_haz(input logic [31:0] inst, input bit v, input bit fl,
                                   output prod_t enter);
    logic [6:0] op;
    int         rs1, rs2, rd;
    bit         ecall, u1, u2, wr, h;
    bit         dep[2];
    op    = inst[6:0];
    rs1   = int'(inst[19:15]);
    rs2   = int'(inst[24:20]);
    rd    = int'(inst[11:7]);
    ecall = (op == OpSystem);
    if (ecall) rs1 = 17;
    u1 = (op != OpJal);
    u2 = (op == OpArith) || (op == OpStore) || (op == OpBranch);
    wr = !((op == OpStore) || (op == OpBranch) || ecall) && (rd != 0);
    for (int a = 0; a < 2; a++) begin
      dep[a] = (hist[a].rd != 0) &&
               ((u1 && rs1 != 0 && rs1 == hist[a].rd) || (u2 && rs2 != 0 && rs2 == hist[a].rd));
    end
`ifdef FORWARD_EN
    h = (dep[0] && hist[0].load) || (ecall && (dep[0] || dep[1]));
`else
    h = dep[0] || dep[1];
`endif
    h = h && v && !fl;
    if (h || fl || !v) begin
      enter.rd   = 0;
      enter.load = 1'b0;
    end else begin
      enter.rd   = wr ? rd : 0;
      enter.load = (op == OpLoad);
    end
    return h;
  endfunction

  task automatic model_clear();
    prod_t z;
    z.rd   = 0;
    z.load = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_cnt = 0;
  endtask

  // One clock cycle: advance the model past the edge, drive inputs, queue the expectation.
  task automatic step(input logic [31:0] inst, input bit v, input bit fl);
    prod_t e;
    exp_t  x;
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (p_haz && m_cnt < CntMax) m_cnt++;
      hist.push_front(p_enter);
      void'(hist.pop_back());
    end
    id_inst  = inst;
    id_valid = v;
    flush    = fl;
    m_haz    = model_haz(inst, v, fl, e);
    p_haz    = m_haz;
    p_enter  = e;
    x.haz    = m_haz;
    x.cnt    = CntW'(m_cnt);
    exp_q.push_back(x);
  endtask

  // Present one instruction, holding it in ID for as long as the model says it stalls.
  // Counts the cycles the DUT actually reported a stall.
  task automatic issue(input logic [31:0] inst, input bit fl, inout int stalls);
    int guard;
    guard = 0;
    do begin
      step(inst, 1'b1, fl);
      #1;
      if (is_hazard === 1'b1) stalls++;
      guard++;
    end while (m_haz && guard < 8);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(32'h0000_0013, 1'b0, 1'b0);
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OpLoad;
      1: return OpStore;
      2: return OpBranch;
      3: return OpJal;
      4: return OpJalr;
      5: return OpArith;
      6: return OpImm;
      7: return OpLui;
      8: return OpAuipc;
      default: return OpSystem;
    endcase
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("is_hazard", is_hazard, e.haz);
        check("pc_write", pc_write, !e.haz);
        check("ifid_write", ifid_write, !e.haz);
        check("stall_count", stall_count, e.cnt);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------------
  initial begin
    int          s1, s2;
    logic [31:0] cur;
    bit          v, fl;

    reset    = 1'b1;
    id_inst  = 32'h0;
    id_valid = 1'b0;
    flush    = 1'b0;
    model_clear();
    p_enter.rd   = 0;
    p_enter.load = 1'b0;
    p_haz        = 1'b0;
    m_haz        = 1'b0;

    bubbles(2);
    check("reset_is_hazard", is_hazard, 1'b0);
    check("reset_pc_write", pc_write, 1'b1);
    check("reset_ifid_write", ifid_write, 1'b1);
    check("reset_stall_count", stall_count, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // lw x5,0(x1) ; add x6,x5,x2
    s1 = 0;
    s2 = 0;
    issue(enc(OpLoad, 5, 1, 0), 1'b0, s1);
    issue(enc(OpArith, 6, 5, 2), 1'b0, s2);
    check("lw_alone_stalls", s1, 0);
    check("lw_use_stalls", s2, LuStalls);
    bubbles(3);
    #1 check("lw_use_count", stall_count, LuStalls);

    // addi x17,x0,10 ; ecall
    s2 = 0;
    issue(enc(OpImm, 17, 0, 10), 1'b0, s1);
    issue(32'h0000_0073, 1'b0, s2);
    check("ecall_stalls", s2, 2);
    bubbles(3);
    #1 check("ecall_count", stall_count, LuStalls + 2);

    // add x0,x1,x2 ; add x3,x0,x0   and   sw x5 ; add x6,x5,x5
    s2 = 0;
    issue(enc(OpArith, 0, 1, 2), 1'b0, s2);
    issue(enc(OpArith, 3, 0, 0), 1'b0, s2);
    issue(enc(OpStore, 0, 1, 5), 1'b0, s2);
    issue(enc(OpArith, 6, 5, 5), 1'b0, s2);
    check("x0_and_store_stalls", s2, 0);
    bubbles(3);

    // lw x5 ; beq x5,x6 flushed in the same cycle
    s2 = 0;
    issue(enc(OpLoad, 5, 1, 0), 1'b0, s1);
    issue(enc(OpBranch, 0, 5, 6), 1'b1, s2);
    check("flush_beats_stall", s2, 0);
    bubbles(3);
    #1 check("flush_count", stall_count, LuStalls + 2);

    // Reset asserted while a stall is being requested
    issue(enc(OpLoad, 5, 1, 0), 1'b0, s1);
    step(enc(OpArith, 6, 5, 2), 1'b1, 1'b0);
    #1 check("pre_reset_stall", is_hazard, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_is_hazard", is_hazard, 1'b0);
    check("async_rst_pc_write", pc_write, 1'b1);
    check("async_rst_ifid_write", ifid_write, 1'b1);
    check("async_rst_stall_count", stall_count, 0);
    bubbles(2);
    @(negedge clk);
    #2 reset = 1'b0;

    // Random traffic over a small register set so dependencies are frequent
    cur = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      if (!m_haz) begin
        cur = enc(pick_op($urandom_range(0, 9)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7));
        v   = ($urandom_range(0, 9) != 0);
      end else begin
        v = 1'b1;
      end
      fl = ($urandom_range(0, 9) == 0);
      step(cur, v, fl);
    end
    bubbles(3);

    // Long load-use chains drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      issue(enc(OpLoad, 5, 1, 0), 1'b0, s1);
      issue(enc(OpArith, 6, 5, 2), 1'b0, s2);
    end
    bubbles(3);
    #1 check("saturated_count", stall_count, CntMax);
    issue(enc(OpLoad, 7, 1, 0), 1'b0, s1);
    issue(enc(OpArith, 6, 7, 2), 1'b0, s2);
    bubbles(3);
    #1 check("no_wrap_count", stall_count, CntMax);

    // Let the monitor drain the scoreboard, with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      check("scoreboard_drain", exp_q.size(), 0);
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
